sig_control_param: RTL and testbench

SIG_CONTROL_PARAM -- requirements
Module: sig_control_param

---
 rtl/sig_control_param.sv | 118 +++++++++++
 tb/tb_sig_control_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sig_control_param.sv
// Highway / country-road traffic-light controller with a maintenance flash mode.
// The phase durations come from the cycle parameters. A single TW-bit dwell
// timer is shared by all phases.
//
// Ports:
//   clock   - single clock, rising edge
//   clear   - synchronous active-high reset
//   sensor  - a vehicle is waiting on the country road
//   flash   - level-sensitive request for maintenance flash mode
//   hwy     - highway light   (RED=0, YELLOW=1, GREEN=2, OFF=3)
//   cntry   - country light   (same encoding as hwy)
//   state_o - current state code, S0..S5
module sig_control_param #(
   parameter int unsigned Y2R_CYCLES      = 3,
   parameter int unsigned R2G_CYCLES      = 2,
   parameter int unsigned MIN_GREEN       = 4,
   parameter int unsigned MAX_CNTRY_GREEN = 8,
   parameter int unsigned TW              = 8
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       sensor,
   input  logic       flash,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S0 = 3'd0,  // highway green,  country red
      S1 = 3'd1,  // highway yellow, country red
      S2 = 3'd2,  // all red
      S3 = 3'd3,  // highway red,    country green
      S4 = 3'd4,  // highway red,    country yellow
      S5 = 3'd5   // maintenance flash
   } state_t;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;
   localparam logic [1:0] OFF    = 2'd3;

   // Last timer value of each timed phase
   localparam logic [TW-1:0] MIN_GREEN_LAST = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] Y2R_LAST       = TW'(Y2R_CYCLES - 1);
   localparam logic [TW-1:0] R2G_LAST       = TW'(R2G_CYCLES - 1);
   localparam logic [TW-1:0] MAX_CG_LAST    = TW'(MAX_CNTRY_GREEN - 1);
   localparam logic [TW-1:0] TIMER_MAX      = '1;

   state_t          r_state;
   state_t          w_next;
   logic [TW-1:0]   r_timer;
   logic            r_phase;

   // Next-state logic. Flash overrides every normal transition.
   always_comb begin
      w_next = r_state;
      if (flash) begin
         w_next = S5;
      end else begin
         unique case (r_state)
            S0: if (sensor && (r_timer >= MIN_GREEN_LAST)) w_next = S1;
            S1: if (r_timer == Y2R_LAST)                   w_next = S2;
            S2: if (r_timer == R2G_LAST)                   w_next = S3;
            S3: if (!sensor || (r_timer == MAX_CG_LAST))   w_next = S4;
            S4: if (r_timer == Y2R_LAST)                   w_next = S0;
            S5: w_next = S0;
            default: w_next = S0;  // unused codes 6 and 7 recover to S0
         endcase
      end
   end

   // State, dwell timer and flash phase. Clear takes priority over everything.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= S0;
         r_timer <= '0;
         r_phase <= 1'b0;
      end else begin
         r_state <= w_next;

         // The timer restarts on every state change and otherwise saturates.
         if (w_next != r_state) begin
            r_timer <= '0;
         end else if (r_timer != TIMER_MAX) begin
            r_timer <= r_timer + TW'(1);
         end

         // The flash phase starts at 0 on entry and alternates while in flash mode.
         if ((w_next == S5) && (r_state == S5)) begin
            r_phase <= ~r_phase;
         end else begin
            r_phase <= 1'b0;
         end
      end
   end

   // Light decode depends only on registered state and phase.
   always_comb begin
      hwy   = RED;
      cntry = RED;
      unique case (r_state)
         S0: hwy   = GREEN;
         S1: hwy   = YELLOW;
         S2: ;
         S3: cntry = GREEN;
         S4: cntry = YELLOW;
         S5: begin
            hwy   = r_phase ? OFF : YELLOW;
            cntry = r_phase ? OFF : RED;
         end
         default: ;
      endcase
   end

   assign state_o = 3'(r_state);

endmodule

// File: tb/tb_sig_control_param.sv
// Testbench for sig_control_param. Directed scenarios are followed by a
// randomized run. Each cycle the expected light and state triple is queued
// from a behavioural model, and a monitor checks the queued value against the DUT.
module tb_sig_control_param;

   localparam int Y2R  = 3;
   localparam int R2G  = 2;
   localparam int MING = 4;
   localparam int MAXG = 8;

   logic       clock;
   logic       clear;
   logic       sensor;
   logic       flash;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic [2:0] state_o;

   sig_control_param #(
      .Y2R_CYCLES     (Y2R),
      .R2G_CYCLES     (R2G),
      .MIN_GREEN      (MING),
      .MAX_CNTRY_GREEN(MAXG),
      .TW             (8)
   ) dut (
      .clock  (clock),
      .clear  (clear),
      .sensor (sensor),
      .flash  (flash),
      .hwy    (hwy),
      .cntry  (cntry),
      .state_o(state_o)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Scoreboard entry: {hwy, cntry, state}
   logic [6:0] sb[$];
   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Behavioural model: the phase name and the number of cycles spent in it
   int m_state = 0;
   int m_dwell = 0;
   int m_ph    = 0;

   // Lights for S0..S4: {highway, country}
   int hwy_tab[5]   = '{2, 1, 0, 0, 0};
   int cntry_tab[5] = '{0, 0, 0, 2, 1};

   function automatic logic [6:0] expected();
      int h, c;
      if (m_state == 5) begin
         h = (m_ph != 0) ? 3 : 1;
         c = (m_ph != 0) ? 3 : 0;
      end else begin
         h = hwy_tab[m_state];
         c = cntry_tab[m_state];
      end
      return {2'(h), 2'(c), 3'(m_state)};
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge
   task automatic model_edge(input logic c, input logic s, input logic f);
      int  nxt;
      bit  leave;
      if (c) begin
         m_state = 0; m_dwell = 0; m_ph = 0;
      end else if (f) begin
         if (m_state == 5) begin
            m_dwell++; m_ph = 1 - m_ph;
         end else begin
            m_state = 5; m_dwell = 0; m_ph = 0;
         end
      end else begin
         leave = 1'b0;
         nxt   = 0;
         case (m_state)
            0: begin leave = s && (m_dwell + 1 >= MING); nxt = 1; end
            1: begin leave = (m_dwell + 1 == Y2R);       nxt = 2; end
            2: begin leave = (m_dwell + 1 == R2G);       nxt = 3; end
            3: begin leave = !s || (m_dwell + 1 == MAXG); nxt = 4; end
            4: begin leave = (m_dwell + 1 == Y2R);       nxt = 0; end
            default: begin leave = 1'b1;                 nxt = 0; end
         endcase
         if (leave) begin
            m_state = nxt; m_dwell = 0;
         end else begin
            m_dwell++;
         end
         m_ph = 0;
      end
   endtask

   // Drive one cycle of inputs, then record the expected response to that edge
   task automatic step(input logic c, input logic s, input logic f);
      @(negedge clock);
      clear  = c;
      sensor = s;
      flash  = f;
      @(posedge clock);
      model_edge(c, s, f);
      sb.push_back(expected());
   endtask

   task automatic run_until(input int target, input logic s);
      for (int n = 0; n < 40 && m_state != target; n++) step(1'b0, s, 1'b0);
   endtask

   // Monitor: the outputs are valid every cycle, so one entry is popped per edge
   initial begin
      logic [6:0] e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({hwy, cntry, state_o} !== e) begin
               n_fail++;
               $display("FAIL out cyc=%0d hwy/cntry/state got %0d/%0d/%0d want %0d/%0d/%0d",
                        cyc, hwy, cntry, state_o, e[6:5], e[4:3], e[2:0]);
            end
         end
         cyc++;
      end
   end

   initial begin
      logic s, f, c;
      clear  = 1'b1;
      sensor = 1'b0;
      flash  = 1'b0;

      // Reset held for two cycles
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      // Sensor held high: minimum green, yellow, all-red, maximum country green and back
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

      // Early release after two cycles of country green
      run_until(3, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

      // Flash entered in the middle of highway yellow, then released
      run_until(1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

      // Clear and flash on the same edge during country green
      run_until(3, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Sensor pulse during highway yellow has no effect on timing
      run_until(1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

      // Clear while flashing
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Randomized traffic with occasional flash requests and clears
      s = 1'b0;
      f = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0)  s = ~s;
         if ($urandom_range(0, 39) == 0) f = ~f;
         c = ($urandom_range(0, 99) == 0);
         step(c, s, f);
      end

      // Every queued expectation must have been consumed
      @(posedge clock);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
